// File: rtl/oled_spi_tx_pkg.sv
// Shared definitions for the OLED SPI transmitter: FSM states, init ROM, panel geometry.
package oled_spi_tx_pkg;

  typedef enum logic [2:0] {
    PWR_UP,
    RST_LOW,
    RST_WAIT,
    INIT,
    VCC_ON,
    DISP_ON,
    STREAM
  } state_t;

  localparam int unsigned INIT_LEN  = 12;
  localparam int unsigned WIDTH     = 96;
  localparam int unsigned HEIGHT    = 64;
  localparam int unsigned NPIX      = WIDTH * HEIGHT;
  localparam int unsigned CNT_MIN_W = 20;

  localparam logic [7:0] CMD_DISP_ON = 8'hAF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Panel init command sequence, sent in index order before vccen is raised
  function automatic logic [7:0] init_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hAE;
      4'd1:    return 8'hA0;
      4'd2:    return 8'h72;
      4'd3:    return 8'hA1;
      4'd4:    return 8'h00;
      4'd5:    return 8'hA2;
      4'd6:    return 8'h00;
      4'd7:    return 8'hA4;
      4'd8:    return 8'hA8;
      4'd9:    return 8'h3F;
      4'd10:   return 8'hAD;
      4'd11:   return 8'h8E;
      default: return 8'hE3;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_tx_spi_shifter.sv
// MSB-first SPI serializer: 8- or 16-bit frames, sclk idles high, 2 cycles per bit,
// followed by one cs-high gap cycle during which done is asserted.
module spi_shifter (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_load,
  input  logic [15:0] i_data,
  input  logic        i_len16,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_cs,
  output logic        o_sclk,
  output logic        o_sdin
);

  logic [15:0] r_sr;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_gap;
  logic        r_len16;
  logic        r_cs;
  logic        r_sclk;
  logic        r_sdin;

  logic        w_accept;
  logic        w_last;

  // A new frame may start while idle or on the gap cycle, giving back-to-back frames
  assign w_accept = i_load && (!r_busy || r_gap);
  assign w_last   = (r_cnt == (r_len16 ? 5'd31 : 5'd15));

  // Shift engine: even half-cycles raise sclk, odd ones drop it and present the next bit
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_gap   <= 1'b0;
      r_len16 <= 1'b0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b1;
      r_sdin  <= 1'b0;
    end else if (w_accept) begin
      r_busy  <= 1'b1;
      r_gap   <= 1'b0;
      r_len16 <= i_len16;
      r_cnt   <= '0;
      r_cs    <= 1'b0;
      r_sclk  <= 1'b0;
      if (i_len16) begin
        r_sdin <= i_data[15];
        r_sr   <= {i_data[14:0], 1'b0};
      end else begin
        r_sdin <= i_data[7];
        r_sr   <= {i_data[6:0], 9'b0};
      end
    end else if (r_gap) begin
      r_busy <= 1'b0;
      r_gap  <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_cnt[0]) begin
        r_sclk <= 1'b1;
      end else if (w_last) begin
        r_cs  <= 1'b1;
        r_gap <= 1'b1;
      end else begin
        r_sclk <= 1'b0;
        r_sdin <= r_sr[15];
        r_sr   <= {r_sr[14:0], 1'b0};
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_gap;
  assign o_cs   = r_cs;
  assign o_sclk = r_sclk;
  assign o_sdin = r_sdin;

endmodule

// File: rtl/oled_spi_tx.sv
// OLED panel controller: power-up/reset/init sequence, then continuous RGB565 pixel streaming.
module oled_spi_tx
  import oled_spi_tx_pkg::*;
#(
  parameter int unsigned PWR_CYCLES = 125,
  parameter int unsigned RST_CYCLES = 19,
  parameter int unsigned VCC_CYCLES = 625000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        streaming,
  output logic        cs,
  output logic        sdin,
  output logic        sclk,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam int unsigned CW =
    max_u(CNT_MIN_W, $clog2(max_u(VCC_CYCLES, max_u(PWR_CYCLES, RST_CYCLES)) + 1));

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_idx;
  logic        r_pmoden;
  logic [12:0] r_pix_idx;

  logic        w_cnt_inc;
  logic        w_load;
  logic        w_len16;
  logic [15:0] w_data;
  logic        w_busy;
  logic        w_done;
  logic        w_ready;

  assign w_ready = !w_busy || w_done;

  spi_shifter u_shifter (
    .i_clk   (CLK),
    .i_rstn  (RSTn),
    .i_load  (w_load),
    .i_data  (w_data),
    .i_len16 (w_len16),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_cs    (cs),
    .o_sclk  (sclk),
    .o_sdin  (sdin)
  );

  // State register, wait counter, init ROM pointer and pixel raster index
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= PWR_UP;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pmoden  <= 1'b0;
      r_pix_idx <= '0;
    end else begin
      r_state  <= w_next;
      r_pmoden <= 1'b1;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_cnt_inc)
        r_cnt <= r_cnt + 1'b1;
      if (w_load && (r_state == INIT))
        r_idx <= r_idx + 4'd1;
      if (w_load && (r_state == STREAM))
        r_pix_idx <= (r_pix_idx == 13'(NPIX - 1)) ? '0 : r_pix_idx + 13'd1;
    end
  end

  // Next-state and shifter load decode; PWR_UP only counts once pmoden is actually high
  always_comb begin
    w_next    = r_state;
    w_cnt_inc = 1'b0;
    w_load    = 1'b0;
    w_len16   = 1'b0;
    w_data    = '0;
    case (r_state)
      PWR_UP: begin
        if (r_pmoden) begin
          if (r_cnt == CW'(PWR_CYCLES - 1)) w_next = RST_LOW;
          else                              w_cnt_inc = 1'b1;
        end
      end
      RST_LOW: begin
        if (r_cnt == CW'(RST_CYCLES - 1)) w_next = RST_WAIT;
        else                              w_cnt_inc = 1'b1;
      end
      RST_WAIT: begin
        if (r_cnt == CW'(RST_CYCLES - 1)) w_next = INIT;
        else                              w_cnt_inc = 1'b1;
      end
      INIT: begin
        w_data = {8'h00, init_rom(r_idx)};
        if (w_ready && (r_idx < 4'(INIT_LEN))) w_load = 1'b1;
        else if (w_done)                       w_next = VCC_ON;
      end
      VCC_ON: begin
        if (r_cnt == CW'(VCC_CYCLES - 1)) w_next = DISP_ON;
        else                              w_cnt_inc = 1'b1;
      end
      DISP_ON: begin
        w_data = {8'h00, CMD_DISP_ON};
        if (!w_busy)     w_load = 1'b1;
        else if (w_done) w_next = STREAM;
      end
      STREAM: begin
        w_len16 = 1'b1;
        w_data  = pixel_data;
        w_load  = w_ready;
      end
      default: w_next = PWR_UP;
    endcase
  end

  assign pmoden       = r_pmoden;
  assign resn         = (r_state != RST_LOW);
  assign vccen        = (r_state inside {VCC_ON, DISP_ON, STREAM});
  assign d_cn         = (r_state == STREAM);
  assign streaming    = (r_state == STREAM);
  assign sample_pixel = w_load && (r_state == STREAM);
  assign frame_begin  = sample_pixel && (r_pix_idx == '0);
  assign pixel_index  = r_pix_idx;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Scoreboard bench for oled_spi_tx: expected SPI frames are queued at stimulus time and
// checked by an independent SPI receiver process.
module tb_oled_spi_tx;

  localparam int unsigned PWR  = 4;
  localparam int unsigned RSTC = 2;
  localparam int unsigned VCC  = 10;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        sample_pixel, frame_begin, streaming;
  logic        cs, sdin, sclk, d_cn, resn, vccen, pmoden;

  oled_spi_tx #(.PWR_CYCLES(PWR), .RST_CYCLES(RSTC), .VCC_CYCLES(VCC)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .pixel_data   (pixel_data),
    .pixel_index  (pixel_index),
    .sample_pixel (sample_pixel),
    .frame_begin  (frame_begin),
    .streaming    (streaming),
    .cs           (cs),
    .sdin         (sdin),
    .sclk         (sclk),
    .d_cn         (d_cn),
    .resn         (resn),
    .vccen        (vccen),
    .pmoden       (pmoden)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0]  len;
    logic [15:0] val;
    logic        dcn;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [7:0] init_bytes [12] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2,
                                  8'h00, 8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_init();
    foreach (init_bytes[i]) exp_q.push_back(exp_t'{6'd8, {8'h00, init_bytes[i]}, 1'b0});
    exp_q.push_back(exp_t'{6'd8, 16'h00AF, 1'b0});
  endtask

  // SPI receiver / scoreboard consumer
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_sdin = 1'b0, rx_act = 1'b0, rx_dcn;
  logic [15:0] rx_val;
  int          rx_bits, rx_low, prev_fall = 0, n_frames = 0, last_rise = 0, af_fall = -1;
  exp_t        e;

  always @(negedge CLK) begin
    if (!RSTn) begin
      rx_act = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b1; prev_sdin = 1'b0; n_frames = 0;
    end else begin
      if (!cs && prev_cs) begin
        rx_act = 1'b1; rx_bits = 0; rx_val = '0; rx_low = 0; rx_dcn = d_cn;
        if (n_frames >= 1 && n_frames <= 11) check("init_byte_spacing", cyc - prev_fall, 17);
        if (n_frames >= 14) check("word_spacing", cyc - prev_fall, 33);
        if (n_frames == 12) af_fall = cyc;
        prev_fall = cyc;
      end
      if (!cs) begin
        rx_low++;
        if (sclk && !prev_sclk) begin
          rx_val = {rx_val[14:0], sdin};
          rx_bits++;
        end
        if (sclk) check("sdin_hold_while_sclk_high", sdin, prev_sdin);
      end
      if (cs && !prev_cs && rx_act) begin
        rx_act    = 1'b0;
        last_rise = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_frame: got 0x%0h required no frame", rx_val);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", rx_bits, e.len);
          check("frame_cs_low_cycles", rx_low, 2 * e.len);
          check("frame_value", rx_val, e.val);
          check("frame_dcn", rx_dcn, e.dcn);
        end
        n_frames++;
      end
      prev_cs = cs; prev_sclk = sclk; prev_sdin = sdin;
    end
  end

  // Power-sequence event recorder
  logic p_pm = 1'b0, p_resn = 1'b1, p_vcc = 1'b0;
  int   pm_rise = -1, resn_fall = -1, resn_rise = -1, vcc_rise = -1, vcc_frames = -1, vcc_gap = -1;

  always @(negedge CLK) begin
    if (pmoden && !p_pm) pm_rise = cyc;
    if (!resn && p_resn) resn_fall = cyc;
    if (resn && !p_resn) resn_rise = cyc;
    if (vccen && !p_vcc) begin
      vcc_rise = cyc; vcc_frames = n_frames; vcc_gap = cyc - last_rise;
    end
    p_pm = pmoden; p_resn = resn; p_vcc = vccen;
  end

  // Pixel source and expected-word producer
  int   k = 0, last_sample = -1, fb_cnt = 0;
  logic mode = 1'b0;

  initial begin
    pixel_data = 16'h0000;
    forever begin
      @(negedge CLK);
      if (!mode) pixel_data = (pixel_index == 13'd0) ? 16'hF800 : 16'h07E0;
      else       pixel_data = 16'($urandom);
      #1;
      if (!RSTn) begin
        k = 0; last_sample = -1; fb_cnt = 0;
      end else if (sample_pixel) begin
        check("pixel_index_at_sample", pixel_index, k % 6144);
        check("frame_begin_at_sample", frame_begin, (k % 6144) == 0);
        check("streaming_at_sample", streaming, 1);
        if (last_sample >= 0) check("sample_spacing", cyc - last_sample, 33);
        if (frame_begin) fb_cnt++;
        exp_q.push_back(exp_t'{6'd16,
                               !mode ? (((k % 6144) == 0) ? 16'hF800 : 16'h07E0) : pixel_data,
                               1'b1});
        last_sample = cyc;
        k++;
      end else begin
        check("frame_begin_without_sample", frame_begin, 0);
      end
    end
  end

  // Main sequence
  int  rel;
  logic found;

  initial begin
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 1);
    check("rst_sdin", sdin, 0);
    check("rst_d_cn", d_cn, 0);
    check("rst_resn", resn, 1);
    check("rst_vccen", vccen, 0);
    check("rst_pmoden", pmoden, 0);
    check("rst_pixel_index", pixel_index, 0);
    check("rst_sample_pixel", sample_pixel, 0);
    check("rst_frame_begin", frame_begin, 0);
    check("rst_streaming", streaming, 0);

    push_init();
    rel  = cyc + 1;
    RSTn = 1'b1;
    for (int i = 0; i < 230000 && k < 6145; i++) @(negedge CLK);
    check("words_streamed_before_timeout", k >= 6145, 1);
    check("frame_begin_pulses_in_6145_words", fb_cnt, 2);
    check("pmoden_rise_cycle", pm_rise, rel);
    check("resn_fall_after_pmoden", resn_fall - pm_rise, PWR);
    check("resn_low_cycles", resn_rise - resn_fall, RSTC);
    check("bytes_before_vccen", vcc_frames, 12);
    check("vccen_after_last_byte", vcc_gap, 1);
    check("disp_on_after_vccen", af_fall - vcc_rise, VCC + 1);

    // Data hold: pixel_data toggles every cycle from here on
    #3 mode = 1'b1;
    for (int i = 0; i < 400 && k < 6150; i++) @(negedge CLK);
    check("toggle_words_before_timeout", k >= 6150, 1);

    // Reset at bit 7 of a streaming word
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      #2 found = sample_pixel;
    end
    check("found_word_start", found, 1);
    repeat (15) @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 1);
    check("abort_sdin", sdin, 0);
    check("abort_vccen", vccen, 0);
    check("abort_pmoden", pmoden, 0);
    check("abort_streaming", streaming, 0);
    check("abort_pixel_index", pixel_index, 0);
    exp_q.delete();
    mode = 1'b0;
    repeat (2) @(negedge CLK);

    push_init();
    rel  = cyc + 1;
    RSTn = 1'b1;
    for (int i = 0; i < 3000 && k < 3; i++) @(negedge CLK);
    check("restart_words_before_timeout", k >= 3, 1);
    check("restart_pmoden_rise_cycle", pm_rise, rel);
    check("restart_resn_fall_after_pmoden", resn_fall - pm_rise, PWR);
    check("restart_bytes_before_vccen", vcc_frames, 12);
    check("restart_frames_outstanding", exp_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
